complex_result_serializer: RTL and testbench
============================================

// Module: complex_result_serializer
// PURPOSE
//  Consumer side of the complex_matrix_mul result interface. Accepts one wide result bundle
//  (SIZE complex FP64 values, packed real/imag) via valid/ready, then streams it out one complex
//  element per beat on a narrow valid/ready stream with index and last flag. Sits between the
//  multiplier's result_o/out_valid_o/out_ready_i and downstream writeback or host-readout logic.
// PARAMETERS
//  SIZE   8   complex elements per bundle; legal range >= 1
//  WIDTH  64  bits per real or imaginary word (IEEE-754 binary64 in normal use)
//  IDX_W  (SIZE>1 ? $clog2(SIZE) : 1)  localparam, element index width
// PORTS
//  clk_i        in   1                 clock
//  rst_ni       in   1                 async active-low reset
//  flush_i      in   1                 sync flush: drop captured bundle, return to IDLE
//  in_valid_i   in   1                 bundle valid (drive from multiplier out_valid_o)
//  in_ready_o   out  1                 bundle accepted when in_valid_i & in_ready_o
//  result_i     in   [2*SIZE-1:0][WIDTH-1:0]  lane 2k = real(k), lane 2k+1 = imag(k)
//  out_valid_o  out  1                 element beat valid
//  out_ready_i  in   1                 downstream ready
//  out_re_o     out  WIDTH             real part of element out_idx_o
//  out_im_o     out  WIDTH             imag part of element out_idx_o
//  out_idx_o    out  IDX_W             element index 0..SIZE-1
//  out_last_o   out  1                 high on beat with out_idx_o == SIZE-1
//  busy_o       out  1                 bundle held and not fully drained
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE, idx=0, bundle register cleared to 0; in_ready_o=1,
//    out_valid_o=0, out_last_o=0, busy_o=0, out_re_o/out_im_o/out_idx_o=0.
//  - FSM: IDLE -> SEND on in handshake (capture whole result_i into bundle reg, idx<=0).
//    SEND: out_valid_o=1, out_re_o=bundle[2*idx], out_im_o=bundle[2*idx+1], out_idx_o=idx.
//    On out handshake with idx<SIZE-1: idx<=idx+1. With idx==SIZE-1: if in_valid_i, capture new
//    bundle, idx<=0, stay SEND; else -> IDLE, idx<=0.
//  - in_ready_o = (state==IDLE) | (state==SEND & idx==SIZE-1 & out_ready_i). Combinational path
//    out_ready_i->in_ready_o is intentional: gives zero-bubble back-to-back bundles.
//  - Latency: bundle accepted at edge N -> element 0 valid after edge N; SIZE beats per bundle at
//    full out_ready_i; throughput one element/cycle sustained across bundles.
//  - Output stability: while out_valid_o & ~out_ready_i, re/im/idx/last held unchanged.
//  - result_i sampled only on in handshake; changes at other times have no effect.
//  - out_valid_o never asserts in IDLE; out_last_o = out_valid_o & (idx==SIZE-1).
//  - SIZE==1: every beat is last; idx stays 0.
//  - busy_o = (state==SEND).
//  - flush_i (priority over all handshakes in the same cycle): next state IDLE, idx<=0, no
//    capture even if in_valid_i high; in_ready_o forced 0 during the flush cycle. Bundle reg
//    contents need not be cleared.
//  - Reset mid-stream: remaining elements discarded, outputs return to reset values immediately.
// STRUCTURE
//  - Shared package cmm_pkg: CMM_SIZE, CMM_WIDTH defaults; typedef cplx_t
//    (struct packed {logic [W-1:0] re, im;}); bundle/lane index helper for lane 2k/2k+1 mapping,
//    shared with complex_matrix_mul and its operand packer.
//  - Single module, no sub-modules: FSM, index counter and bundle register inline; output mux
//    indexed by idx.
// TESTING (SIZE=8, WIDTH=64 unless noted)
//  1 Reset: hold rst_ni=0 with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, busy_o=0, no capture.
//  2 Single bundle, out_ready_i=1: lanes real(k)=$realtobits(k+1.0), imag(k)=$realtobits(-(k+1.0))
//    -> 8 consecutive beats idx 0..7, beat 0 re=64'h3FF0000000000000 im=64'hBFF0000000000000,
//    out_last_o only on idx 7, then IDLE.
//  3 Backpressure: out_ready_i random 50% -> same 8 values in order, outputs stable while stalled,
//    no beat dropped or duplicated.
//  4 Back-to-back: in_valid_i held high with two distinct bundles -> 16 beats, no idle cycle
//    between idx 7 and second bundle's idx 0; second bundle captured on first bundle's last beat.
//  5 Flush at idx 3 with in_valid_i=1 -> flush cycle in_ready_o=0, next cycle IDLE, out_valid_o=0;
//    following bundle restarts at idx 0.
//  6 SIZE=1 build: one bundle -> single beat, idx 0, out_last_o=1, back to IDLE.

Source files
------------

// File: rtl/cmm_pkg.sv
// Shared types and defaults for the complex matrix multiplier result path.
// The lane helpers define the real/imag packing of a result bundle.
package cmm_pkg;

  localparam int unsigned CMM_SIZE  = 8;
  localparam int unsigned CMM_WIDTH = 64;

  typedef struct packed {
    logic [CMM_WIDTH-1:0] re;
    logic [CMM_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Element k occupies lane 2k (real) and lane 2k+1 (imag).
  function automatic int unsigned re_lane(input int unsigned k);
    return k << 1;
  endfunction

  function automatic int unsigned im_lane(input int unsigned k);
    return (k << 1) | 32'd1;
  endfunction

endpackage

// File: rtl/complex_result_serializer_if.sv
// Wide bundle input and narrow per-element output stream of the result serializer.
interface complex_result_serializer_if
  import cmm_pkg::*;
#(
  parameter int unsigned SIZE  = CMM_SIZE,
  parameter int unsigned WIDTH = CMM_WIDTH
);
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [2*SIZE-1:0][WIDTH-1:0]    result_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [WIDTH-1:0]                out_re_o;
  logic [WIDTH-1:0]                out_im_o;
  logic [IDX_W-1:0]                out_idx_o;
  logic                            out_last_o;

  modport slave (
    input  in_valid_i, result_i, out_ready_i,
    output in_ready_o, out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o
  );

  modport master (
    output in_valid_i, result_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o
  );
endinterface

// File: rtl/complex_result_serializer.sv
// Captures one wide complex result bundle and streams it out one element per beat.
// in_ready_o combinationally follows out_ready_i on the last beat so bundles chain without bubbles.
module complex_result_serializer
  import cmm_pkg::*;
#(
  parameter int unsigned SIZE  = CMM_SIZE,
  parameter int unsigned WIDTH = CMM_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic busy_o,
  complex_result_serializer_if.slave bus
);

  localparam int unsigned      IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned      LANE_W   = $clog2(2 * SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  ser_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [2*SIZE-1:0][WIDTH-1:0] bundle_q, bundle_d;
  logic                         in_ready_c;
  logic                         is_last_c;
  logic [LANE_W-1:0]            lane_re_c, lane_im_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bundle_q <= bundle_d;
    end
  end

  assign is_last_c = (idx_q == LAST_IDX);

  // Next state; flush overrides every handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bundle_d   = bundle_q;
    in_ready_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid_i) begin
          state_d  = ST_SEND;
          idx_d    = '0;
          bundle_d = bus.result_i;
        end
      end
      ST_SEND: begin
        if (bus.out_ready_i) begin
          if (is_last_c) begin
            in_ready_c = 1'b1;
            idx_d      = '0;
            if (bus.in_valid_i) begin
              bundle_d = bus.result_i;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      bundle_d   = bundle_q;
      in_ready_c = 1'b0;
    end
  end

  assign lane_re_c = LANE_W'(re_lane(32'(idx_q)));
  assign lane_im_c = LANE_W'(im_lane(32'(idx_q)));

  assign bus.in_ready_o  = in_ready_c;
  assign bus.out_valid_o = (state_q == ST_SEND);
  assign bus.out_last_o  = (state_q == ST_SEND) && is_last_c;
  assign bus.out_re_o    = bundle_q[lane_re_c];
  assign bus.out_im_o    = bundle_q[lane_im_c];
  assign bus.out_idx_o   = idx_q;
  assign busy_o          = (state_q == ST_SEND);

endmodule

// File: tb/tb_complex_result_serializer.sv
// Randomized scoreboard bench for complex_result_serializer (SIZE=8 plus a SIZE=1 instance).
module tb_complex_result_serializer;
  import cmm_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned W = 64;

  typedef logic [2*N-1:0][W-1:0] bundle_t;
  typedef struct {
    cplx_t v;
    int    idx;
    bit    last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy, busy1;
  always #5 clk = ~clk;

  complex_result_serializer_if #(.SIZE(N), .WIDTH(W)) bus ();
  complex_result_serializer_if #(.SIZE(1), .WIDTH(W)) bus1 ();

  complex_result_serializer #(.SIZE(N), .WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy), .bus(bus));
  complex_result_serializer #(.SIZE(1), .WIDTH(W)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .busy_o(busy1), .bus(bus1));

  beat_t exp_q[$];
  int checks = 0, passes = 0;
  int run_len = 0, max_run = 0;
  bit prev_beat = 0;
  bit bp_mode = 0, hold_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a bundle becomes SIZE beats in element order.
  task automatic push_bundle(input bundle_t b);
    beat_t e;
    for (int k = 0; k < int'(N); k++) begin
      e.v.re = b[2*k];
      e.v.im = b[2*k+1];
      e.idx  = k;
      e.last = (k == int'(N) - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    for (int l = 0; l < int'(2*N); l++) b[l] = {$urandom, $urandom};
    return b;
  endfunction

  task automatic send_bundle(input bundle_t b);
    bit ok = 0;
    bus.in_valid_i = 1'b1;
    bus.result_i   = b;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        push_bundle(b);
        ok = 1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
      end
    end
    if (!ok) chk("in_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    chk({name, "_drained"}, 64'(ok), 64'd1);
    @(posedge clk); #3;
    chk({name, "_idle_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  // Ready driver: full rate, random backpressure, or forced low.
  always @(posedge clk) begin
    #1;
    if (hold_ready) bus.out_ready_i = 1'b0;
    else if (bp_mode) bus.out_ready_i = 1'($urandom_range(0, 1));
    else bus.out_ready_i = 1'b1;
  end

  // Monitor: compares accepted beats against the model, and stalled beats against the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.out_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got idx %0d expected no beat", bus.out_idx_o);
      end else begin
        e = exp_q[0];
        if (bus.out_re_o === e.v.re && bus.out_im_o === e.v.im &&
            int'(bus.out_idx_o) == e.idx && bus.out_last_o === e.last) passes++;
        else $display("FAIL %s: got idx %0d re %h im %h last %b expected idx %0d re %h im %h last %b",
                      bus.out_ready_i ? "beat" : "stall_hold", bus.out_idx_o, bus.out_re_o,
                      bus.out_im_o, bus.out_last_o, e.idx, e.v.re, e.v.im, e.last);
        if (bus.out_ready_i) void'(exp_q.pop_front());
      end
    end
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      run_len = prev_beat ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      prev_beat = 1;
    end else begin
      prev_beat = 0;
    end
  end

  initial begin
    bundle_t b;
    bundle_t bn;
    logic [1:0][W-1:0] r1;
    bus.in_valid_i = 1'b1;
    bus.result_i   = rand_bundle();
    bus.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0;
    bus1.result_i   = '0;
    bus1.out_ready_i = 1'b0;

    // Reset held with in_valid high
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(bus.out_last_o), 64'd0);
    chk("rst_re", bus.out_re_o, 64'd0);
    chk("rst_idx", 64'(bus.out_idx_o), 64'd0);
    bus.in_valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #3;
    chk("post_rst_no_capture", 64'(bus.out_valid_o), 64'd0);

    // Single directed bundle at full rate
    for (int k = 0; k < int'(N); k++) begin
      b[2*k]   = $realtobits(real'(k) + 1.0);
      b[2*k+1] = $realtobits(-(real'(k) + 1.0));
    end
    chk("model_beat0_re", b[0], 64'h3FF0000000000000);
    send_bundle(b);
    wait_drain("single");

    // Random backpressure with random bundle gaps
    bp_mode = 1;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_bundle(rand_bundle());
    end
    wait_drain("backpressure");
    bp_mode = 0;

    // Back-to-back bundles must stream with no bubble
    @(posedge clk); #1;
    max_run = 0;
    send_bundle(rand_bundle());
    send_bundle(rand_bundle());
    wait_drain("b2b");
    chk("b2b_run_len", 64'(max_run), 64'(2*N));

    // Flush at idx 3 with a pending bundle on the input
    send_bundle(rand_bundle());
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge clk); #3;
        if (bus.out_valid_o && bus.out_idx_o == 3'd3) seen = 1;
      end
      chk("flush_reach_idx3", 64'(seen), 64'd1);
    end
    bn = rand_bundle();
    hold_ready = 1;
    bus.out_ready_i = 1'b0;
    flush = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.result_i = bn;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk); #3;
    exp_q.delete();
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    flush = 1'b0;
    hold_ready = 0;
    bus.out_ready_i = 1'b1;
    send_bundle(bn);
    wait_drain("after_flush");

    // SIZE=1 instance
    r1[0] = $realtobits(1.0);
    r1[1] = $realtobits(-1.0);
    @(posedge clk); #1;
    bus1.in_valid_i = 1'b1;
    bus1.result_i   = r1;
    @(negedge clk);
    chk("s1_in_ready", 64'(bus1.in_ready_o), 64'd1);
    @(posedge clk); #1;
    bus1.in_valid_i = 1'b0;
    bus1.result_i   = '0;
    @(negedge clk);
    chk("s1_valid", 64'(bus1.out_valid_o), 64'd1);
    chk("s1_idx", 64'(bus1.out_idx_o), 64'd0);
    chk("s1_last", 64'(bus1.out_last_o), 64'd1);
    chk("s1_re", bus1.out_re_o, 64'h3FF0000000000000);
    chk("s1_im", bus1.out_im_o, 64'hBFF0000000000000);
    bus1.out_ready_i = 1'b1;
    @(posedge clk); #3;
    chk("s1_idle_valid", 64'(bus1.out_valid_o), 64'd0);
    chk("s1_idle_busy", 64'(busy1), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
